pipe_stage_reg: RTL and testbench

- Parametrised pipeline stage register; generalises the fixed MEM/WB-style register to any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Adds valid/ready handshake, a 2-entry skid buffer for back-pressure without combinational ready paths, synchronous flush with bubble insertion, and a combinational early-forward tap.
- Instantiated once per stage boundary by the pipeline top; the hazard unit drives the flush input.

---
 rtl/pipe_stage_reg.sv | 171 +++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready handshake, 2-entry skid
// buffer, synchronous flush and a combinational early-forward tap.
// Optional performance counters are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 2,
    parameter int RD_W   = 5
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [RD_W-1:0]   i_rd,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [RD_W-1:0]   o_rd,
    output logic [DATA_W-1:0] o_data,
    output logic              o_fwd_valid,
    output logic [RD_W-1:0]   o_fwd_rd,
`ifdef PIPE_STAGE_PERF_EN
    output logic [DATA_W-1:0] o_fwd_data,
    output logic [31:0]       o_stall_cnt,
    output logic [31:0]       o_flush_cnt
`else
    output logic [DATA_W-1:0] o_fwd_data
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic                valid_r;
    logic                ready_r;
    logic [CTRL_W-1:0]   out_ctrl_r;
    logic [RD_W-1:0]     out_rd_r;
    logic [DATA_W-1:0]   out_data_r;
    logic [CTRL_W-1:0]   skid_ctrl_r;
    logic [RD_W-1:0]     skid_rd_r;
    logic [DATA_W-1:0]   skid_data_r;
    logic                accept_s;
    logic                take_s;
    logic                load_in_s;
    logic                load_skid_s;
    logic                stash_s;

    assign accept_s = i_valid & ready_r;
    assign take_s   = valid_r & i_ready;

    // Next-state and datapath load selection; flush overrides any accept/take.
    always_comb begin
        state_nxt_s = state_r;
        load_in_s   = 1'b0;
        load_skid_s = 1'b0;
        stash_s     = 1'b0;
        if (i_flush) begin
            state_nxt_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_nxt_s = ST_FULL;
                        load_in_s   = 1'b1;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (accept_s && take_s) begin
                        state_nxt_s = ST_FULL;
                        load_in_s   = 1'b1;
                    end else if (accept_s) begin
                        state_nxt_s = ST_SKID;
                        stash_s     = 1'b1;
                    end else if (take_s) begin
                        state_nxt_s = ST_EMPTY;
                    end else begin
                        state_nxt_s = ST_FULL;
                    end
                end
                ST_SKID: begin
                    if (take_s) begin
                        state_nxt_s = ST_FULL;
                        load_skid_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_SKID;
                    end
                end
                default: begin
                    state_nxt_s = ST_EMPTY;
                end
            endcase
        end
    end

    // State, handshake flags and entry storage; flush leaves payload registers untouched.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r     <= ST_EMPTY;
            valid_r     <= 1'b0;
            ready_r     <= 1'b1;
            out_ctrl_r  <= {CTRL_W{1'b0}};
            out_rd_r    <= {RD_W{1'b0}};
            out_data_r  <= {DATA_W{1'b0}};
            skid_ctrl_r <= {CTRL_W{1'b0}};
            skid_rd_r   <= {RD_W{1'b0}};
            skid_data_r <= {DATA_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            valid_r <= (state_nxt_s != ST_EMPTY);
            ready_r <= (state_nxt_s != ST_SKID);
            if (load_in_s) begin
                out_ctrl_r <= i_ctrl;
                out_rd_r   <= i_rd;
                out_data_r <= i_data;
            end else if (load_skid_s) begin
                out_ctrl_r <= skid_ctrl_r;
                out_rd_r   <= skid_rd_r;
                out_data_r <= skid_data_r;
            end
            if (stash_s) begin
                skid_ctrl_r <= i_ctrl;
                skid_rd_r   <= i_rd;
                skid_data_r <= i_data;
            end
        end
    end

    assign o_valid = valid_r;
    assign o_ready = ready_r;
    // Write enables must never leak out on a bubble.
    assign o_ctrl  = out_ctrl_r & {CTRL_W{valid_r}};
    assign o_rd    = out_rd_r;
    assign o_data  = out_data_r;

    assign o_fwd_valid = i_valid & ~i_flush;
    assign o_fwd_rd    = i_rd;
    assign o_fwd_data  = i_data;

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] flush_cnt_r;

    // Stall and non-empty flush event counters; only reset clears them.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            stall_cnt_r <= 32'd0;
            flush_cnt_r <= 32'd0;
        end else begin
            if (valid_r && !i_ready) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end
            if (i_flush && (state_r != ST_EMPTY)) begin
                flush_cnt_r <= flush_cnt_r + 32'd1;
            end
        end
    end

    assign o_stall_cnt = stall_cnt_r;
    assign o_flush_cnt = flush_cnt_r;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus random traffic
// compared against a 2-deep FIFO reference model.
module tb_pipe_stage_reg;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 2;
    localparam int RD_W   = 5;

    typedef struct {
        logic [CTRL_W-1:0] ctrl;
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] data;
    } ent_t;

    logic              clk = 1'b0;
    logic              reset, flush, valid_in, ready_in;
    logic [CTRL_W-1:0] ctrl_in;
    logic [RD_W-1:0]   rd_in;
    logic [DATA_W-1:0] data_in;
    logic              ready_out, valid_out, fwd_valid;
    logic [CTRL_W-1:0] ctrl_out;
    logic [RD_W-1:0]   rd_out, fwd_rd;
    logic [DATA_W-1:0] data_out, fwd_data;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]       stall_cnt, flush_cnt;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    ent_t    q[$];
    ent_t    held;
    int unsigned m_stall = 0;
    int unsigned m_flush = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .RD_W(RD_W)) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_flush    (flush),
        .i_valid    (valid_in),
        .o_ready    (ready_out),
        .i_ctrl     (ctrl_in),
        .i_rd       (rd_in),
        .i_data     (data_in),
        .o_valid    (valid_out),
        .i_ready    (ready_in),
        .o_ctrl     (ctrl_out),
        .o_rd       (rd_out),
        .o_data     (data_out),
        .o_fwd_valid(fwd_valid),
        .o_fwd_rd   (fwd_rd),
`ifdef PIPE_STAGE_PERF_EN
        .o_fwd_data (fwd_data),
        .o_stall_cnt(stall_cnt),
        .o_flush_cnt(flush_cnt)
`else
        .o_fwd_data (fwd_data)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: the stage behaves as a FIFO of at most two entries.
    task automatic model_edge(input logic v, input logic f, input logic r, input logic rst, input ent_t e);
        bit tk, ac;
        if (rst) begin
            q.delete();
            held    = '{ctrl: '0, rd: '0, data: '0};
            m_stall = 0;
            m_flush = 0;
        end else begin
            tk = (q.size() > 0) && r;
            ac = v && (q.size() < 2);
            if ((q.size() > 0) && !r) m_stall++;
            if (f && (q.size() > 0)) m_flush++;
            if (f) begin
                q.delete();
            end else begin
                if (tk) void'(q.pop_front());
                if (ac) q.push_back(e);
            end
            if (q.size() > 0) held = q[0];
        end
    endtask

    task automatic check_outputs();
        bit ev;
        ev = (q.size() > 0);
        check_eq("o_valid", 64'(valid_out), 64'(ev));
        check_eq("o_ready", 64'(ready_out), 64'(q.size() < 2));
        check_eq("o_ctrl",  64'(ctrl_out),  ev ? 64'(held.ctrl) : 64'd0);
        check_eq("o_rd",    64'(rd_out),    64'(held.rd));
        check_eq("o_data",  64'(data_out),  64'(held.data));
`ifdef PIPE_STAGE_PERF_EN
        check_eq("stall_cnt", 64'(stall_cnt), 64'(m_stall));
        check_eq("flush_cnt", 64'(flush_cnt), 64'(m_flush));
`endif
    endtask

    // One clock: drive at negedge, check taps, let the edge pass, check registered outputs.
    task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic [RD_W-1:0] rd,
                        input logic [CTRL_W-1:0] c, input logic r, input logic f, input logic rst);
        ent_t e;
        valid_in = v; data_in = d; rd_in = rd; ctrl_in = c;
        ready_in = r; flush = f; reset = rst;
        e = '{ctrl: c, rd: rd, data: d};
        #1;
        check_eq("fwd_valid", 64'(fwd_valid), 64'(v & ~f));
        check_eq("fwd_rd",    64'(fwd_rd),    64'(rd));
        check_eq("fwd_data",  64'(fwd_data),  64'(d));
        @(posedge clk);
        model_edge(v, f, r, rst, e);
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        valid_in = 1'b0; ready_in = 1'b0; flush = 1'b0; reset = 1'b1;
        ctrl_in = '0; rd_in = '0; data_in = '0;
        @(negedge clk);

        // Reset then a back-to-back stream
        step(1'b0, 32'h0, 5'd0, 2'b00, 1'b1, 1'b0, 1'b1);
        step(1'b0, 32'h0, 5'd0, 2'b00, 1'b1, 1'b0, 1'b1);
        check_eq("reset_valid", 64'(valid_out), 64'd0);
        check_eq("reset_data",  64'(data_out),  64'd0);
        step(1'b1, 32'h11, 5'd1, 2'b01, 1'b1, 1'b0, 1'b0);
        check_eq("stream_0", 64'(data_out), 64'h11);
        step(1'b1, 32'h22, 5'd2, 2'b01, 1'b1, 1'b0, 1'b0);
        check_eq("stream_1", 64'(data_out), 64'h22);
        step(1'b1, 32'h33, 5'd3, 2'b01, 1'b1, 1'b0, 1'b0);
        check_eq("stream_2", 64'(data_out), 64'h33);
        step(1'b0, 32'h0, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0);

        // Back-pressure into the skid entry, then drain in order
        step(1'b1, 32'hA, 5'd10, 2'b01, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'hB, 5'd11, 2'b10, 1'b0, 1'b0, 1'b0);
        check_eq("skid_ready", 64'(ready_out), 64'd0);
        check_eq("skid_hold",  64'(data_out),  64'hA);
        step(1'b0, 32'h0, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0);
        check_eq("skid_drain", 64'(data_out), 64'hB);
        step(1'b0, 32'h0, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0);

        // Flush while in SKID with a concurrent input that must vanish
        step(1'b1, 32'hA, 5'd10, 2'b01, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'hB, 5'd11, 2'b01, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hC, 5'd12, 2'b11, 1'b0, 1'b1, 1'b0);
        check_eq("flush_valid", 64'(valid_out), 64'd0);
        check_eq("flush_ctrl",  64'(ctrl_out),  64'd0);
        step(1'b0, 32'h0, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0);

        // Bubble masking of control
        step(1'b1, 32'h44, 5'd4, 2'b11, 1'b1, 1'b0, 1'b0);
        check_eq("bubble_ctrl_on", 64'(ctrl_out), 64'd3);
        step(1'b0, 32'h0, 5'd0, 2'b11, 1'b1, 1'b0, 1'b0);
        check_eq("bubble_ctrl_off", 64'(ctrl_out), 64'd0);

        // Reset mid-operation from SKID
        step(1'b1, 32'h5, 5'd5, 2'b01, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h7, 5'd6, 2'b01, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b1);
        check_eq("midreset_rd", 64'(rd_out), 64'd0);
        step(1'b1, 32'h6, 5'd9, 2'b01, 1'b1, 1'b0, 1'b0);
        check_eq("after_reset", 64'(data_out), 64'h6);
        step(1'b0, 32'h0, 5'd0, 2'b00, 1'b1, 1'b0, 1'b0);

        // Forward tap with and without flush, then three stalled cycles
        step(1'b1, 32'hDEAD, 5'd7, 2'b00, 1'b1, 1'b1, 1'b1);
        step(1'b1, 32'hDEAD, 5'd7, 2'b01, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0);
`ifdef PIPE_STAGE_PERF_EN
        check_eq("stall_three", 64'(stall_cnt), 64'd3);
`endif

        // Random traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 3) != 0),
                 $urandom(),
                 5'($urandom_range(0, 31)),
                 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 127) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
